data_sram_slave: RTL and testbench

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

---
 rtl/data_sram_slave.sv | 121 ++++++++++++
 tb/tb_data_sram_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_slave.sv
// Word-organised SRAM slave with a fixed accept-to-response latency.
// Accesses are read-first: the response carries the word as it was before any byte writes.
module data_sram_slave #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    input  logic        resp_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [2:0] CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    state_t                state_q;
    logic [2:0]            cnt_q;
    logic [3:0]            we_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [31:0]           wdata_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_rdata_q;
    logic [31:0]           mem_q [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  unused_addr_bits;
    logic                  accept;
    logic                  busy_done;
    logic                  access;
    logic [DEPTH_LOG2-1:0] acc_idx;
    logic [3:0]            acc_we;
    logic [31:0]           acc_wdata;

    // Byte offset and bits above the array size are dropped, so addresses alias modulo depth.
    assign req_idx          = req_addr[DEPTH_LOG2+1:2];
    assign unused_addr_bits = ^{req_addr[31:DEPTH_LOG2+2], req_addr[1:0]};

    assign req_ready = (state_q == IDLE) || ((state_q == RESP) && resp_ready);
    assign accept    = req_en && req_ready;
    assign busy_done = (state_q == BUSY) && (cnt_q == 3'd0);

    // The access happens on the edge entering RESP: the accept edge itself when LATENCY is 1,
    // otherwise the edge that ends the BUSY countdown using the captured request.
    always_comb begin
        access    = busy_done || (accept && (LATENCY == 1));
        acc_idx   = busy_done ? idx_q   : req_idx;
        acc_we    = busy_done ? we_q    : req_we;
        acc_wdata = busy_done ? wdata_q : req_wdata;
    end

    // NOTE: the array has no reset so it maps onto SRAM; reset only suppresses the write strobe.
    always_ff @(posedge clk) begin
        if (access && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_we[i]) begin
                    mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignments here make every register sample pre-edge values,
    // which is what gives the read-first behaviour against the write block above.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            we_q         <= 4'd0;
            idx_q        <= '0;
            wdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            if (access) begin
                resp_rdata_q <= mem_q[acc_idx];
            end
            if (accept) begin
                we_q    <= req_we;
                idx_q   <= req_idx;
                wdata_q <= req_wdata;
                if (LATENCY == 1) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                end else begin
                    state_q      <= BUSY;
                    cnt_q        <= CNT_INIT;
                    resp_valid_q <= 1'b0;
                end
            end else begin
                unique case (state_q)
                    BUSY: begin
                        if (cnt_q == 3'd0) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end
                    RESP: begin
                        if (resp_ready) begin
                            state_q      <= IDLE;
                            resp_valid_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_sram_slave.sv
// Three slaves (LATENCY 1, 3, 4) driven one at a time; a reference memory model feeds a
// scoreboard queue that a separate monitor drains whenever a slave presents a response.
module tb_data_sram_slave;

    localparam int N  = 3;
    localparam int DL = 10;

    function automatic int lat_of(int i);
        case (i)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   req_en;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [N-1:0]   resp_ready;
    logic [3:0]     req_we     [N];
    logic [31:0]    req_addr   [N];
    logic [31:0]    req_wdata  [N];
    logic [31:0]    resp_rdata [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        data_sram_slave #(.DEPTH_LOG2(DL), .LATENCY(lat_of(g))) u_dut (
            .clk        (clk),
            .reset      (reset),
            .req_en     (req_en[g]),
            .req_we     (req_we[g]),
            .req_addr   (req_addr[g]),
            .req_wdata  (req_wdata[g]),
            .req_ready  (req_ready[g]),
            .resp_valid (resp_valid[g]),
            .resp_rdata (resp_rdata[g]),
            .resp_ready (resp_ready[g])
        );
    end

    typedef struct {
        int          d;
        logic [31:0] data;
        bit          chk;
        int          acc;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] mem_m [N][1024];
    logic [3:0]  kmask [N][1024];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          mon_off = 1'b0;
    bit          rand_bp = 1'b0;
    int          stall_cnt [N];
    bit [N-1:0]  prev_valid;
    bit [N-1:0]  prev_hs;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, int d, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s dut=%0d cyc=%0d got %h want %h", nm, d, cyc, act, expv);
        end
    endtask

    // Response-side backpressure: forced stalls first, then optional random throttling.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (stall_cnt[i] > 0) begin
                resp_ready[i] = 1'b0;
                stall_cnt[i]--;
            end else if (rand_bp) begin
                resp_ready[i] = ($urandom_range(0, 3) != 0);
            end else begin
                resp_ready[i] = 1'b1;
            end
        end
    end

    // Monitor: checks presentation time, data, stability and req_ready against the scoreboard.
    always @(negedge clk) begin
        #1;
        if (reset || mon_off) begin
            prev_valid = '0;
            prev_hs    = '0;
        end else begin
            for (int d = 0; d < N; d++) begin
                int f;
                f = -1;
                for (int k = 0; k < exp_q.size(); k++) begin
                    if (exp_q[k].d == d && exp_q[k].acc <= cyc) begin
                        f = k;
                        break;
                    end
                end
                if (resp_valid[d]) begin
                    if (f < 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp dut=%0d cyc=%0d got resp_valid=1 want 0", d, cyc);
                    end else begin
                        if (!prev_valid[d] || prev_hs[d])
                            check("resp_latency", d, cyc, exp_q[f].acc + lat_of(d) - 1);
                        if (exp_q[f].chk)
                            check("resp_rdata", d, resp_rdata[d], exp_q[f].data);
                        check("req_ready_in_resp", d, 32'(req_ready[d]), 32'(resp_ready[d]));
                        if (resp_ready[d]) exp_q.delete(f);
                    end
                end else if (f >= 0) begin
                    check("req_ready_busy", d, 32'(req_ready[d]), 32'd0);
                    if (cyc > exp_q[f].acc + lat_of(d) - 1) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_resp dut=%0d cyc=%0d got resp_valid=0 want 1", d, cyc);
                        exp_q.delete(f);
                    end
                end else begin
                    check("req_ready_idle", d, 32'(req_ready[d]), 32'd1);
                end
                prev_valid[d] = resp_valid[d];
                prev_hs[d]    = resp_valid[d] && resp_ready[d];
            end
        end
    end

    // Reference behaviour: read-first word access with per-byte writes, aliasing on bits [11:2].
    task automatic model_access(input int d, input logic [3:0] we, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] old, output bit chk);
        int idx;
        idx = int'(addr[11:2]);
        old = mem_m[d][idx];
        chk = (kmask[d][idx] == 4'hF);
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem_m[d][idx][8*b +: 8] = wd[8*b +: 8];
                kmask[d][idx][b]        = 1'b1;
            end
        end
    endtask

    // Called and returns at posedge+1; the request is held until the slave accepts it.
    task automatic do_req(int d, logic [3:0] we, logic [31:0] addr, logic [31:0] wd);
        logic [31:0] old;
        bit          chk;
        exp_t        e;
        req_en[d]    = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                model_access(d, we, addr, wd, old, chk);
                e.d    = d;
                e.data = old;
                e.chk  = chk;
                e.acc  = cyc + 1;
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                req_en[d] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout dut=%0d cyc=%0d got req_ready=0 want 1", d, cyc);
        req_en[d] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
            #1;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout cyc=%0d got %0d pending want 0", cyc, exp_q.size());
        exp_q.delete();
    endtask

    task automatic finish_reset();
        reset   = 1'b0;
        mon_off = 1'b0;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check("reset_req_ready", d, 32'(req_ready[d]), 32'd1);
            check("reset_resp_valid", d, 32'(resp_valid[d]), 32'd0);
            check("reset_resp_rdata", d, resp_rdata[d], 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset(int n);
        reset = 1'b1;
        exp_q.delete();
        repeat (n) @(posedge clk);
        #1;
        finish_reset();
    endtask

    // Issues one request and resets the slaves k edges after its accept edge (k=0: same edge).
    // Only a write whose access edge precedes the reset edge reaches memory.
    task automatic abort_txn(int d, logic [3:0] we, logic [31:0] addr, logic [31:0] wd, int k);
        logic [31:0] old;
        bit          chk;
        mon_off      = 1'b1;
        req_en[d]    = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wd;
        if (k == 0) begin
            reset = 1'b1;
            exp_q.delete();
        end
        @(negedge clk);
        check("abort_accept_ready", d, 32'(req_ready[d]), 32'd1);
        @(posedge clk);
        #1;
        req_en[d] = 1'b0;
        if (k >= lat_of(d)) model_access(d, we, addr, wd, old, chk);
        if (k == 0) begin
            finish_reset();
        end else begin
            repeat (k - 1) begin
                @(posedge clk);
                #1;
            end
            pulse_reset(1);
        end
    endtask

    task automatic set_stall(int d, int n);
        @(negedge clk);
        stall_cnt[d] = n;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  we;
        int          idx;
        req_en = '0;
        for (int d = 0; d < N; d++) begin
            req_we[d]    = 4'd0;
            req_addr[d]  = 32'd0;
            req_wdata[d] = 32'd0;
            for (int i = 0; i < 1024; i++) kmask[d][i] = 4'd0;
        end
        pulse_reset(3);

        // Give words 0..15 of every slave known contents.
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < 16; i++) do_req(d, 4'hF, 32'(i) << 2, $urandom());
            wait_drain();
        end

        // LATENCY=1: write then read, byte merge, and a back-to-back stream including addr 0x4.
        do_req(0, 4'hF, 32'h10, 32'hDEADBEEF);
        do_req(0, 4'h0, 32'h10, 32'h0);
        do_req(0, 4'hF, 32'h20, 32'h11223344);
        do_req(0, 4'b0101, 32'h20, 32'hAABBCCDD);
        do_req(0, 4'h0, 32'h20, 32'h0);
        do_req(0, 4'h0, 32'h4, 32'h0);
        do_req(0, 4'h3, 32'h4, 32'h5A5A5A5A);
        do_req(0, 4'h0, 32'h4, 32'h0);
        wait_drain();

        // LATENCY=4: plain read, then a response held off by backpressure.
        do_req(2, 4'h0, 32'h10, 32'h0);
        wait_drain();
        set_stall(2, 9);
        do_req(2, 4'hF, 32'h14, 32'h0F0F1234);
        wait_drain();
        do_req(2, 4'h0, 32'h14, 32'h0);
        wait_drain();

        // Resets that abort transactions; reads afterwards show memory untouched.
        do_req(1, 4'hF, 32'h8, 32'hCAFEF00D);
        wait_drain();
        abort_txn(1, 4'hF, 32'h8, 32'h12345678, 1);
        do_req(1, 4'h0, 32'h1008, 32'h0);
        wait_drain();
        abort_txn(1, 4'hF, 32'h8, 32'h87654321, 2);
        do_req(1, 4'h0, 32'h8, 32'h0);
        wait_drain();
        abort_txn(0, 4'hF, 32'h10, 32'h0BADF00D, 0);
        do_req(0, 4'h0, 32'h10, 32'h0);
        wait_drain();
        set_stall(2, 12);
        abort_txn(2, 4'h0, 32'h20, 32'h0, 5);
        do_req(2, 4'h0, 32'h20, 32'h0);
        wait_drain();

        // Randomised traffic with aliased addresses, byte enables and throttled responses.
        rand_bp = 1'b1;
        for (int d = 0; d < N; d++) begin
            for (int n = 0; n < 60; n++) begin
                idx = $urandom_range(0, 15);
                we  = ($urandom_range(0, 1) == 1) ? 4'($urandom()) : 4'h0;
                a   = ($urandom() & 32'hFFFF_F000) | (32'(idx) << 2) | ($urandom() & 32'h3);
                do_req(d, we, a, $urandom());
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            wait_drain();
        end
        rand_bp = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", -1, 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
